// File: rtl/tdm_demux_4ch_pkg.sv
// Shared types and constants for the 4-channel TDM de-interleaver.
package tdm_demux_4ch_pkg;

  localparam int SLOT_W = 2;
  localparam int NUM_CH = 4;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/tdm_frame_buf.sv
// Parallel-frame output register with a valid/ready handshake.
// A frame arriving while an unaccepted frame is held is dropped and flagged.
module tdm_frame_buf
  import tdm_demux_4ch_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_i,
  input  logic [NUM_CH-1:0][DATA_W-1:0] frame_i,
  input  logic                          ready_i,
  output logic [NUM_CH-1:0][DATA_W-1:0] frame_o,
  output logic                          valid_o,
  output logic                          overrun_o
);

  logic [NUM_CH-1:0][DATA_W-1:0] frame_q, frame_d;
  logic                          valid_q, valid_d;
  logic                          overrun_q, overrun_d;

  always_comb begin
    frame_d   = frame_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load_i) begin
      // An accept in the same cycle frees the register for the new frame.
      if (!valid_q || ready_i) begin
        frame_d = frame_i;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      frame_q   <= frame_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign frame_o   = frame_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/tdm_demux_4ch.sv
// De-interleaves a 4-slot TDM stream (slot 0 marked by frame_sync) into
// parallel channel frames presented with a valid/ready handshake.
module tdm_demux_4ch
  import tdm_demux_4ch_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [DATA_W-1:0] out_0,
  output logic [DATA_W-1:0] out_1,
  output logic [DATA_W-1:0] out_2,
  output logic [DATA_W-1:0] out_3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sync_err,
  output logic              overrun
);

  state_e state_q, state_d;
  slot_t  slot_q, slot_d;
  logic   sync_err_q, sync_err_d;
  logic   wr_en;
  slot_t  wr_idx;
  logic   complete;

  // The last slot feeds the frame straight from din, so only the first
  // NUM_CH-1 samples need holding.
  logic [DATA_W-1:0]             shadow_q [NUM_CH-1];
  logic [NUM_CH-1:0][DATA_W-1:0] frame_in;
  logic [NUM_CH-1:0][DATA_W-1:0] frame_out;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    sync_err_d = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = '0;
    complete   = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync) begin
            wr_en   = 1'b1;
            slot_d  = slot_t'(1);
            state_d = LOCK;
          end
        end
        LOCK: begin
          if (frame_sync) begin
            sync_err_d = (slot_q != '0);
            wr_en      = 1'b1;
            slot_d     = slot_t'(1);
          end else if (slot_q == '0) begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
          end else begin
            wr_en    = 1'b1;
            wr_idx   = slot_q;
            slot_d   = slot_t'(slot_q + slot_t'(1));
            complete = (slot_q == slot_t'(NUM_CH - 1));
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      slot_q     <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      sync_err_q <= sync_err_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH - 1; gi++) begin : g_shadow
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_q[gi] <= '0;
        end else if (wr_en && wr_idx == slot_t'(gi)) begin
          shadow_q[gi] <= din;
        end
      end
      assign frame_in[gi] = shadow_q[gi];
    end
  endgenerate

  assign frame_in[NUM_CH-1] = din;

  tdm_frame_buf #(
    .DATA_W(DATA_W)
  ) u_frame_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (complete),
    .frame_i  (frame_in),
    .ready_i  (out_ready),
    .frame_o  (frame_out),
    .valid_o  (out_valid),
    .overrun_o(overrun)
  );

  assign out_0    = frame_out[0];
  assign out_1    = frame_out[1];
  assign out_2    = frame_out[2];
  assign out_3    = frame_out[3];
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Bench for tdm_demux_4ch: directed scenarios plus random traffic, checked
// every cycle against a queue-based frame-assembly model.
module tb_tdm_demux_4ch;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          frame_sync = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_0, out_1, out_2, out_3;
  logic          out_valid, sync_err, overrun;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit            locked;
  logic [DW-1:0] cur[$];
  logic [DW-1:0] ofr[4];
  bit            ov, e_err, e_ovr;

  tdm_demux_4ch #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .frame_sync(frame_sync),
    .out_0     (out_0),
    .out_1     (out_1),
    .out_2     (out_2),
    .out_3     (out_3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sync_err  (sync_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    locked = 1'b0;
    cur.delete();
    for (int i = 0; i < 4; i++) ofr[i] = '0;
    ov    = 1'b0;
    e_err = 1'b0;
    e_ovr = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit fs, input logic [DW-1:0] d, input bit rdy);
    bit            done;
    logic [DW-1:0] f[4];
    done  = 1'b0;
    e_err = 1'b0;
    e_ovr = 1'b0;
    if (v) begin
      if (fs) begin
        if (locked && cur.size() != 0) e_err = 1'b1;
        cur.delete();
        cur.push_back(d);
        locked = 1'b1;
      end else if (locked) begin
        if (cur.size() == 0) begin
          e_err  = 1'b1;
          locked = 1'b0;
        end else begin
          cur.push_back(d);
          if (cur.size() == 4) begin
            done = 1'b1;
            for (int i = 0; i < 4; i++) f[i] = cur[i];
            cur.delete();
          end
        end
      end
    end
    if (done) begin
      if (!ov || rdy) begin
        ofr = f;
        ov  = 1'b1;
        $display("frame out: %h %h %h %h", f[0], f[1], f[2], f[3]);
      end else begin
        e_ovr = 1'b1;
        $display("frame dropped: %h %h %h %h", f[0], f[1], f[2], f[3]);
      end
    end else if (ov && rdy) begin
      ov = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".frame"}, 32'({out_3, out_2, out_1, out_0}),
          32'({ofr[3], ofr[2], ofr[1], ofr[0]}));
    check({tag, ".sync_err"}, 32'(sync_err), 32'(e_err));
    check({tag, ".overrun"}, 32'(overrun), 32'(e_ovr));
  endtask

  task automatic step(input bit v, input bit fs, input logic [DW-1:0] d, input bit rdy);
    din_valid  = v;
    frame_sync = fs;
    din        = d;
    out_ready  = rdy;
    @(posedge clk);
    model_step(v, fs, d, rdy);
    #1 check_outputs("cycle");
  endtask

  task automatic frame(input logic [DW-1:0] a, b, c, d, input bit rdy);
    step(1'b1, 1'b1, a, rdy);
    step(1'b1, 1'b0, b, rdy);
    step(1'b1, 1'b0, c, rdy);
    step(1'b1, 1'b0, d, rdy);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 4'(($urandom_range(15))), rdy);
  endtask

  // Assert reset away from any clock edge and check outputs clear at once.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int tslot;
    bit v, fs, rdy;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // clean frame
    frame(4'hA, 4'hB, 4'hC, 4'hD, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // beats before the first sync are discarded
    async_reset();
    step(1'b1, 1'b0, 4'h5, 1'b1);
    step(1'b1, 1'b0, 4'h6, 1'b1);
    frame(4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    idle(1'b1);

    // early sync
    step(1'b1, 1'b1, 4'h1, 1'b1);
    step(1'b1, 1'b0, 4'h2, 1'b1);
    frame(4'h9, 4'h8, 4'h7, 4'h6, 1'b1);
    idle(1'b1);

    // missing sync returns to hunting
    frame(4'h1, 4'h2, 4'h3, 4'h4, 1'b1);
    step(1'b1, 1'b0, 4'h5, 1'b1);
    frame(4'h6, 4'h7, 4'h8, 4'h9, 1'b1);
    idle(1'b1);

    // backpressure and overrun
    frame(4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
    frame(4'h5, 4'h6, 4'h7, 4'h8, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // accept-and-reload with din_valid gaps inside the new frame
    frame(4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
    step(1'b1, 1'b1, 4'h5, 1'b0);
    idle(1'b0);
    step(1'b1, 1'b0, 4'h6, 1'b0);
    step(1'b1, 1'b0, 4'h7, 1'b0);
    idle(1'b0);
    step(1'b1, 1'b0, 4'h8, 1'b1);
    idle(1'b0);

    // reset mid-frame while a frame is held
    step(1'b1, 1'b1, 4'hE, 1'b0);
    step(1'b1, 1'b0, 4'hF, 1'b0);
    async_reset();
    step(1'b1, 1'b0, 4'h3, 1'b1);
    frame(4'h2, 4'h4, 4'h6, 4'h8, 1'b1);
    idle(1'b1);

    // random traffic with occasional sync faults and backpressure bursts
    tslot = 0;
    for (int i = 0; i < 3000; i++) begin
      v  = ($urandom_range(3) != 0);
      fs = (tslot == 0);
      if ($urandom_range(19) == 0) fs = !fs;
      rdy = ((i % 200) < 40) ? 1'b0 : ($urandom_range(2) != 0);
      step(v, fs, 4'($urandom_range(15)), rdy);
      if (v) tslot = fs ? 1 : (tslot + 1) % 4;
      if (i == 1500) begin
        async_reset();
        tslot = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
